// File: rtl/button_event.sv
// rtl/button_event.sv - button press/release, short/long press and auto-repeat event generator
//
// Turns a debounced, clock-synchronous button level into single-cycle event pulses.
//
// Parameters
//   longCount   : PRESSED-state hold cycles before a long press is declared (1..2^26-1)
//   repeatCount : REPEAT-state cycles between auto-repeat pulses (1..2^26-1)
//
// Ports
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high reset
//   dataIn       : debounced button level, 1 = pressed
//   press        : one-cycle pulse at the start of a press
//   releasePulse : one-cycle pulse at the end of a press ("release" is a reserved word)
//   shortPress   : one-cycle pulse for a press released before the long threshold
//   longPress    : one-cycle pulse when the long threshold is reached
//   repeatPulse  : one-cycle auto-repeat pulse ("repeat" is a reserved word)
//   held         : level, 1 whenever the state is not IDLE
//   pressCount   : running count of press pulses, wraps 255 -> 0
//
// All outputs are registered.

module button_event #(
    parameter logic [25:0] longCount   = 26'd50000000,
    parameter logic [25:0] repeatCount = 26'd10000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dataIn,
    output logic       press,
    output logic       releasePulse,
    output logic       shortPress,
    output logic       longPress,
    output logic       repeatPulse,
    output logic       held,
    output logic [7:0] pressCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [25:0] delay;
    logic [25:0] delay_nxt;
    logic        press_nxt;
    logic        release_nxt;
    logic        short_nxt;
    logic        long_nxt;
    logic        repeat_nxt;
    logic [7:0]  count_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            delay        <= 26'd0;
            press        <= 1'b0;
            releasePulse <= 1'b0;
            shortPress   <= 1'b0;
            longPress    <= 1'b0;
            repeatPulse  <= 1'b0;
            held         <= 1'b0;
            pressCount   <= 8'd0;
        end else begin
            state        <= state_nxt;
            delay        <= delay_nxt;
            press        <= press_nxt;
            releasePulse <= release_nxt;
            shortPress   <= short_nxt;
            longPress    <= long_nxt;
            repeatPulse  <= repeat_nxt;
            held         <= (state_nxt != IDLE);
            pressCount   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        short_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        count_nxt   = pressCount;

        case (state)
            IDLE: begin
                if (dataIn) begin
                    state_nxt = PRESSED;
                    delay_nxt = longCount;
                    press_nxt = 1'b1;
                    count_nxt = pressCount + 8'd1;
                end else begin
                    delay_nxt = 26'd0;
                end
            end

            PRESSED: begin
                // Checking the level first lets a release in the expiry cycle win.
                if (!dataIn) begin
                    state_nxt   = IDLE;
                    delay_nxt   = 26'd0;
                    release_nxt = 1'b1;
                    short_nxt   = 1'b1;
                end else if (delay == 26'd0) begin
                    state_nxt  = REPEAT;
                    delay_nxt  = repeatCount;
                    long_nxt   = 1'b1;
                    repeat_nxt = 1'b1;
                end else begin
                    delay_nxt = delay - 26'd1;
                end
            end

            REPEAT: begin
                if (!dataIn) begin
                    state_nxt   = IDLE;
                    delay_nxt   = 26'd0;
                    release_nxt = 1'b1;
                end else if (delay == 26'd0) begin
                    delay_nxt  = repeatCount;
                    repeat_nxt = 1'b1;
                end else begin
                    delay_nxt = delay - 26'd1;
                end
            end

            default: begin
                // Unused encoding: recover silently.
                state_nxt = IDLE;
                delay_nxt = 26'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - scoreboard testbench for button_event (longCount=4, repeatCount=2)

module tb_button_event;

    logic       clock;
    logic       reset;
    logic       dataIn;
    logic       press;
    logic       releasePulse;
    logic       shortPress;
    logic       longPress;
    logic       repeatPulse;
    logic       held;
    logic [7:0] pressCount;

    button_event #(
        .longCount   (26'd4),
        .repeatCount (26'd2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dataIn       (dataIn),
        .press        (press),
        .releasePulse (releasePulse),
        .shortPress   (shortPress),
        .longPress    (longPress),
        .repeatPulse  (repeatPulse),
        .held         (held),
        .pressCount   (pressCount)
    );

    // pulse vector order: {press, release, shortPress, longPress, repeat}
    localparam logic [4:0] EV_PRESS = 5'b10000;
    localparam logic [4:0] EV_SHORT = 5'b01100;
    localparam logic [4:0] EV_LONG  = 5'b00011;
    localparam logic [4:0] EV_RPT   = 5'b00001;
    localparam logic [4:0] EV_REL   = 5'b01000;

    typedef struct {
        int         cyc;
        logic [4:0] pulses;
        logic       held;
        logic [7:0] cnt;
    } event_t;

    event_t     exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;
    logic [7:0] exp_cnt = 8'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clock);
        #1;
    endtask

    task automatic push(input int c, input logic [4:0] p, input logic h);
        event_t e;
        e.cyc    = c;
        e.pulses = p;
        e.held   = h;
        e.cnt    = exp_cnt;
        exp_q.push_back(e);
    endtask

    // Hold the button for h edges starting from the current cycle c, then release.
    // Press shows at c+1, the long threshold at c+6, repeats every 3 cycles after,
    // and release at c+h+1 (release wins over a coinciding expiry).
    task automatic press_hold(input int h);
        int c;
        c = cyc;
        exp_cnt = exp_cnt + 8'd1;
        push(c + 1, EV_PRESS, 1'b1);
        if (h <= 5) begin
            push(c + h + 1, EV_SHORT, 1'b0);
        end else begin
            push(c + 6, EV_LONG, 1'b1);
            for (int k = 1; 6 + 3 * k <= h; k++) push(c + 6 + 3 * k, EV_RPT, 1'b1);
            push(c + h + 1, EV_REL, 1'b0);
        end
        dataIn = 1'b1;
        tick(h);
        dataIn = 1'b0;
        tick(2);
    endtask

    task automatic check_idle(input string name);
        @(negedge clock);
        check({name, " pulses"}, int'({press, releasePulse, shortPress, longPress, repeatPulse}), 0);
        check({name, " held"}, int'(held), 0);
        check({name, " pressCount"}, int'(pressCount), 0);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest expectation.
    always @(negedge clock) begin
        logic [4:0] p;
        event_t     e;
        p = {press, releasePulse, shortPress, longPress, repeatPulse};
        if (!reset && (|p) === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected pulse", int'(p), 0);
            end else begin
                e = exp_q.pop_front();
                check("event cycle", cyc, e.cyc);
                check("event pulses", int'(p), int'(e.pulses));
                check("event held", int'(held), int'(e.held));
                check("event pressCount", int'(pressCount), int'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        reset  = 1'b1;
        dataIn = 1'b1;
        tick(3);
        check_idle("reset overrides dataIn");
        dataIn = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        exp_cnt = 8'd0;

        // 256 short presses: counter wraps back to 0
        for (int i = 0; i < 256; i++) press_hold(1);
        tick(1);
        check("wrap pressCount", int'(pressCount), 0);

        press_hold(3);   // short press
        press_hold(5);   // release in the exact expiry cycle of PRESSED
        press_hold(6);   // long press, release right after
        press_hold(8);   // release coincides with REPEAT expiry
        press_hold(12);  // long + two repeats
        tick(1);
        check("pressCount after presses", int'(pressCount), 5);

        // Reset mid-REPEAT with the button still held
        c = cyc;
        exp_cnt = exp_cnt + 8'd1;
        push(c + 1, EV_PRESS, 1'b1);
        push(c + 6, EV_LONG, 1'b1);
        dataIn = 1'b1;
        tick(8);
        reset = 1'b1;
        exp_cnt = 8'd0;
        tick(1);
        check_idle("reset mid-repeat");
        tick(1);
        reset = 1'b0;
        c = cyc;
        exp_cnt = 8'd1;
        push(c + 1, EV_PRESS, 1'b1);
        tick(2);
        push(c + 3, EV_SHORT, 1'b0);
        dataIn = 1'b0;
        tick(4);
        check("pressCount after reset", int'(pressCount), 1);
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter: longCount, default 26'd50000000, PRESSED-state hold cycles before a long press is declared; legal range 1..2^26-1.
REQ-002 Parameter: repeatCount, default 26'd10000000, REPEAT-state cycles between auto-repeat pulses; legal range 1..2^26-1.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 dataIn  input  1  debounced, clock-synchronous button level from the upstream debouncer; 1 = pressed.
REQ-006 press  output  1  one-cycle pulse marking the start of a press.
REQ-007 release  output  1  one-cycle pulse marking the end of a press.
REQ-008 shortPress  output  1  one-cycle pulse for a press released before the long threshold.
REQ-009 longPress  output  1  one-cycle pulse when the long threshold is reached.
REQ-010 repeat  output  1  one-cycle auto-repeat pulse while held past the long threshold.
REQ-011 held  output  1  level, 1 whenever the state is not IDLE.
REQ-012 pressCount  output  8  running count of press pulses.

Function
REQ-013 The block SHALL implement three states: IDLE, PRESSED, REPEAT, with a 26-bit down-counter `delay` and all outputs registered.
REQ-014 In IDLE with dataIn=1 at an edge, the block SHALL enter PRESSED, load delay=longCount, and assert press for exactly the following cycle.
REQ-015 In IDLE with dataIn=0, the block SHALL stay in IDLE and hold delay at 0.
REQ-016 In PRESSED with dataIn=0, the block SHALL enter IDLE and assert release and shortPress together for one cycle.
REQ-017 In PRESSED with dataIn=1 and delay!=0, delay SHALL decrement by 1 per cycle.
REQ-018 In PRESSED with dataIn=1 and delay==0, the block SHALL enter REPEAT, load delay=repeatCount, and assert longPress and repeat together for one cycle.
REQ-019 Resulting timing: press in cycle t implies longPress/repeat in cycle t+longCount+1.
REQ-020 In REPEAT with dataIn=1 and delay==0, the block SHALL reload delay=repeatCount and pulse repeat; repeat period = repeatCount+1 cycles.
REQ-021 In REPEAT with dataIn=1 and delay!=0, delay SHALL decrement by 1 per cycle.
REQ-022 In REPEAT with dataIn=0, the block SHALL enter IDLE and pulse release only (no shortPress).
REQ-023 Simultaneous release and expiry (dataIn=0 with delay==0): release SHALL win; the expiry pulse is not emitted.
REQ-024 pressCount SHALL increment in the cycle press asserts and wrap from 255 to 0.
REQ-025 An illegal state encoding SHALL return to IDLE on the next edge with no pulse.
REQ-026 press, release, shortPress, longPress and repeat SHALL never be high for more than one consecutive cycle.

Reset
REQ-027 With reset=1 at an edge, the block SHALL enter IDLE, clear delay and pressCount to 0, and drive every output to 0 in the next cycle.
REQ-028 Reset SHALL override dataIn and any in-progress press.
REQ-029 Reset asserted mid-press SHALL produce no release pulse.
REQ-030 After reset deasserts with dataIn already 1, the block SHALL treat the level as a new press, pulsing press one cycle later.

Verification (longCount=4, repeatCount=2)
REQ-031 Short press: dataIn high 3 cycles then low -> one press pulse, then release+shortPress together, no longPress; pressCount=1.
REQ-032 Long hold: press at cycle t -> longPress+repeat at t+5, then repeat at t+8 and t+11; dataIn low -> release only, no shortPress.
REQ-033 Boundary: dataIn falls in the exact cycle delay==0 in PRESSED -> release+shortPress, no longPress.
REQ-034 Wrap: 256 short presses -> pressCount returns to 0, each press a single-cycle pulse.
REQ-035 Reset mid-REPEAT -> all outputs 0 next cycle, no release; dataIn still 1 after reset drops -> press one cycle later, pressCount=1.
